dl_proc_detect_unit: RTL

Per-process deadlock detector for the dataflow co-simulation testbench; one instance per dataflow process (polyphase_filter, fft config, be). It builds the process's transitive wait set and flags a self-detected dependence cycle on `dl_detect_out`, which drives that process's bit of the deadlock report unit's `dl_in_vec`. After global detection it runs the token walk that lets the report unit trace and print each circle, ending on the report unit's `token_clear`.

---
 rtl/dl_proc_detect_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dl_proc_detect_unit.sv
// dl_proc_detect_unit
// Per-process deadlock detector. Builds this process's transitive wait set,
// flags a self-detected dependence cycle, and after global detection takes
// part in the token walk that lets the report unit trace each circle.
// Optional feature macro: DL_PERSIST_FILTER_EN -- when defined, a cycle
// condition must persist DL_WAIT cycles before self-detect; when undefined,
// self-detect is the cycle condition delayed by one register.
module dl_proc_detect_unit #(
  parameter int PROC_NUM   = 3,
  parameter int MY_PROC_ID = 0,
  parameter int DEP_NUM    = 2,
  parameter int DL_WAIT    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        proc_blocked,
  input  logic [DEP_NUM-1:0]          dep_vld,
  input  logic [DEP_NUM*PROC_NUM-1:0] dep_data_in,
  output logic [PROC_NUM-1:0]         dep_data_out,
  input  logic                        dl_detect_in,
  input  logic                        origin,
  input  logic [DEP_NUM-1:0]          token_in,
  output logic [DEP_NUM-1:0]          token_out,
  input  logic                        token_clear,
  output logic                        dl_detect_out
);

  typedef enum logic [2:0] {
    S_MON  = 3'd0,
    S_WAIT = 3'd1,
    S_ORIG = 3'd2,
    S_TOK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Elaboration-time guard on the configuration range
  if (MY_PROC_ID < 0 || MY_PROC_ID >= PROC_NUM || DL_WAIT < 1 || DL_WAIT > 255) begin : g_bad_cfg
    $error("dl_proc_detect_unit: parameter out of range");
  end

  logic [PROC_NUM-1:0] wait_set;
  logic [DEP_NUM-1:0]  hit;
  logic                cyc;
  logic [DEP_NUM-1:0]  sel_onehot;
  logic                sel_found;
  logic                self_dl;
  state_t              state;
  logic                is_orig;

  // Wait set, per-neighbour cycle hits and the cycle condition
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wait_set = '0;
    hit      = '0;
    if (proc_blocked) begin
      wait_set[MY_PROC_ID] = 1'b1;
      for (int j = 0; j < DEP_NUM; j++) begin
        if (dep_vld[j]) wait_set = wait_set | dep_data_in[j*PROC_NUM +: PROC_NUM];
      end
    end
    for (int j = 0; j < DEP_NUM; j++) begin
      hit[j] = dep_vld[j] & dep_data_in[j*PROC_NUM + MY_PROC_ID];
    end
    cyc = proc_blocked & (|hit);
  end

  // Next hop: lowest neighbour that closes the cycle, else lowest blocking neighbour
  always_comb begin
    sel_onehot = '0;
    sel_found  = 1'b0;
    for (int j = 0; j < DEP_NUM; j++) begin
      if (!sel_found && hit[j]) begin
        sel_onehot[j] = 1'b1;
        sel_found     = 1'b1;
      end
    end
    for (int j = 0; j < DEP_NUM; j++) begin
      if (!sel_found && dep_vld[j]) begin
        sel_onehot[j] = 1'b1;
        sel_found     = 1'b1;
      end
    end
  end

  // Registered wait set, published to the neighbours
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) dep_data_out <= '0;
    else        dep_data_out <= wait_set;
  end

`ifdef DL_PERSIST_FILTER_EN
  localparam logic [7:0] WAIT_MAX = 8'(DL_WAIT);
  logic [7:0] cnt;

  // Persistence counter: saturates at DL_WAIT, clears whenever the cycle breaks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               cnt <= 8'd0;
    else if (!cyc)            cnt <= 8'd0;
    else if (cnt != WAIT_MAX) cnt <= cnt + 8'd1;
  end

  assign self_dl = (cnt == WAIT_MAX);
`else
  logic self_dl_q;

  // Unfiltered self-detect: cycle condition delayed by one register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) self_dl_q <= 1'b0;
    else        self_dl_q <= cyc;
  end

  assign self_dl = self_dl_q;
`endif

  // Walk controller; token_clear outside monitoring overrides every other transition
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_MON;
      is_orig <= 1'b0;
    end else if (token_clear && state != S_MON) begin
      state   <= S_WAIT;
      is_orig <= 1'b0;
    end else begin
      case (state)
        S_MON:   if (dl_detect_in) state <= S_WAIT;
        S_WAIT: begin
          if (origin) begin
            state   <= S_ORIG;
            is_orig <= 1'b1;
          end else if (|token_in) begin
            state <= S_TOK;
          end
        end
        S_ORIG:  state <= S_DONE;
        S_TOK:   state <= S_DONE;
        S_DONE:  if (is_orig && (|token_in)) state <= S_TOK;
        default: state <= S_MON;
      endcase
    end
  end

  // Output decode from registered state; token pass suppressed by token_clear
  always_comb begin
    dl_detect_out = 1'b0;
    token_out     = '0;
    case (state)
      S_MON:  dl_detect_out = self_dl;
      S_ORIG: token_out     = sel_onehot;
      S_TOK: begin
        dl_detect_out = 1'b1;
        token_out     = sel_onehot;
      end
      default: ;
    endcase
    if (token_clear) token_out = '0;
  end

endmodule
